// File: rtl/fpga_cmd_pkg.sv
// Shared constants and types for the ARM-to-FPGA SPI command receiver.
package fpga_cmd_pkg;

  localparam logic [3:0] CMD_SET_CONFREG = 4'b0001;
  localparam logic [3:0] CMD_SET_DIVISOR = 4'b0010;

  localparam logic [4:0] FRAME_LEN = 5'd16;
  localparam logic [4:0] COUNT_MAX = 5'd17;

  localparam logic [2:0] MAJOR_HF_READER_TX       = 3'b000;
  localparam logic [2:0] MAJOR_HF_READER_RX_XCORR = 3'b001;
  localparam logic [2:0] MAJOR_HF_SIMULATOR       = 3'b010;
  localparam logic [2:0] MAJOR_HF_ISO14443A       = 3'b011;
  localparam logic [2:0] MAJOR_LF_READER          = 3'b100;
  localparam logic [2:0] MAJOR_OFF                = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_e;

  function automatic logic [3:0] frame_opcode(input logic [15:0] frame);
    return frame[15:12];
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchronizer for an asynchronous input, with rise/fall strobes
// taken from the last two stages.
module sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/fpga_cmd_rx.sv
// Receives 16-bit SPI command frames from the ARM and updates the
// configuration and divisor registers once a frame closes cleanly.
module fpga_cmd_rx
  import fpga_cmd_pkg::*;
#(
  parameter logic [7:0] CONF_RESET = 8'hE0,
  parameter logic [7:0] DIV_RESET  = 8'd95
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic       spck,
  input  logic       mosi,
  input  logic       ncs,
  output logic [7:0] conf_word,
  output logic [2:0] major_mode,
  output logic [7:0] divisor,
  output logic       conf_strobe,
  output logic       frame_err
);

  logic spck_rise, unused_spck_sync, unused_spck_fall;
  logic mosi_sync, unused_mosi_rise, unused_mosi_fall;
  logic ncs_sync, ncs_rise, ncs_fall;

  sync_edge u_sync_spck (
    .clk_i   (ck_1356meg),
    .reset_i (reset),
    .d_i     (spck),
    .q_o     (unused_spck_sync),
    .rise_o  (spck_rise),
    .fall_o  (unused_spck_fall)
  );

  sync_edge u_sync_mosi (
    .clk_i   (ck_1356meg),
    .reset_i (reset),
    .d_i     (mosi),
    .q_o     (mosi_sync),
    .rise_o  (unused_mosi_rise),
    .fall_o  (unused_mosi_fall)
  );

  sync_edge u_sync_ncs (
    .clk_i   (ck_1356meg),
    .reset_i (reset),
    .d_i     (ncs),
    .q_o     (ncs_sync),
    .rise_o  (ncs_rise),
    .fall_o  (ncs_fall)
  );

  state_e      state_q, state_d;
  logic [15:0] shift_q;
  logic [4:0]  count_q;
  logic        clear_frame, shift_en;
  logic        commit_conf, commit_div, commit_err;
  logic [7:0]  conf_word_q, divisor_q;
  logic        conf_strobe_q, frame_err_q;

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ncs_fall) state_d = StShift;
      StShift:  if (ncs_rise) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    clear_frame = 1'b0;
    shift_en    = 1'b0;
    commit_conf = 1'b0;
    commit_div  = 1'b0;
    commit_err  = 1'b0;
    unique case (state_q)
      StIdle: clear_frame = ncs_fall;
      StShift: begin
        // A re-select restarts the frame; a close wins over a coincident spck edge.
        if (ncs_fall) begin
          clear_frame = 1'b1;
        end else if (!ncs_rise && spck_rise && !ncs_sync) begin
          shift_en = 1'b1;
        end
      end
      StCommit: begin
        if (count_q != FRAME_LEN) begin
          commit_err = 1'b1;
        end else if (frame_opcode(shift_q) == CMD_SET_CONFREG) begin
          commit_conf = 1'b1;
        end else if (frame_opcode(shift_q) == CMD_SET_DIVISOR) begin
          commit_div = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (clear_frame) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[14:0], mosi_sync};
      count_q <= (count_q == COUNT_MAX) ? COUNT_MAX : count_q + 5'd1;
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      conf_word_q   <= CONF_RESET;
      divisor_q     <= DIV_RESET;
      conf_strobe_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      if (commit_conf) conf_word_q <= shift_q[7:0];
      if (commit_div)  divisor_q   <= shift_q[7:0];
      conf_strobe_q <= commit_conf | commit_div;
      frame_err_q   <= commit_err;
    end
  end

  assign conf_word   = conf_word_q;
  assign major_mode  = conf_word_q[7:5];
  assign divisor     = divisor_q;
  assign conf_strobe = conf_strobe_q;
  assign frame_err   = frame_err_q;

endmodule
